// File: rtl/tanh_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tanh_share_arbiter
// Brief    : Round-robin sequencer sharing one start/ready tanh core among
//            N_REQ requesters. Define TANH_ARB_TIMEOUT_EN for the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tanh_share_arbiter #(
    parameter int N_REQ     = 4,
    parameter int W         = 16,
    parameter int TO_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_x,
    output logic [N_REQ-1:0]         req_ack,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [W-1:0]             rsp_y,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     core_start,
    output logic [W-1:0]             core_x,
    input  logic                     core_ready,
    input  logic [W-1:0]             core_y
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDW-1:0]   r_ptr, w_ptr_nxt;
    logic [IDW-1:0]   r_grant, w_grant_nxt;
    logic [IDW-1:0]   w_pick;
    logic [IDW:0]     w_sum;
    logic             w_found;
    logic [W-1:0]     w_x [N_REQ];
    logic [N_REQ-1:0] r_ack, w_ack_nxt;
    logic [N_REQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
    logic [W-1:0]     r_core_x, w_core_x_nxt;
    logic [W-1:0]     r_rsp_y, w_rsp_y_nxt;
    logic             r_start, w_start_nxt;
    logic             r_busy;
    logic             r_err, w_err_nxt;
    logic             w_timeout;

    if (N_REQ < 2 || TO_CYCLES < 1) begin : g_param_chk
        $error("tanh_share_arbiter: N_REQ must be >= 2 and TO_CYCLES >= 1");
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_x[gi] = req_x[gi*W +: W];
    end

    // Search starts one past the last served requester, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N_REQ)) begin
                w_sum = w_sum - (IDW+1)'(N_REQ);
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDW-1:0];
            end
        end
    end

`ifdef TANH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0] r_to_cnt;
    logic          w_waiting;

    assign w_waiting = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);

    always_ff @(posedge clk) begin
        if (rst || !w_waiting) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + CW'(1);
        end
    end

    assign w_timeout = w_waiting && (r_to_cnt == CW'(TO_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_grant_nxt     = r_grant;
        w_core_x_nxt    = r_core_x;
        w_rsp_y_nxt     = r_rsp_y;
        w_ack_nxt       = '0;
        w_rsp_valid_nxt = '0;
        w_start_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = S_ISSUE;
                    w_grant_nxt  = w_pick;
                    w_core_x_nxt = w_x[w_pick];
                    w_start_nxt  = 1'b1;
                    w_ack_nxt    = N_REQ'(1) << w_pick;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (w_timeout) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_y_nxt     = '0;
                    w_err_nxt       = 1'b1;
                    w_rsp_valid_nxt = N_REQ'(1) << r_grant;
                end else if (!core_ready) begin
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                // A result arriving on the watchdog's last cycle still wins.
                if (core_ready) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_y_nxt     = core_y;
                    w_rsp_valid_nxt = N_REQ'(1) << r_grant;
                end else if (w_timeout) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_y_nxt     = '0;
                    w_err_nxt       = 1'b1;
                    w_rsp_valid_nxt = N_REQ'(1) << r_grant;
                end
            end
            S_RESP: begin
                w_ptr_nxt   = r_grant;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= IDW'(N_REQ - 1);
            r_grant     <= '0;
            r_core_x    <= '0;
            r_rsp_y     <= '0;
            r_ack       <= '0;
            r_rsp_valid <= '0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_core_x    <= w_core_x_nxt;
            r_rsp_y     <= w_rsp_y_nxt;
            r_ack       <= w_ack_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_start     <= w_start_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign req_ack    = r_ack;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_y      = r_rsp_y;
    assign rsp_err    = r_err;
    assign busy       = r_busy;
    assign grant_id   = r_grant;
    assign core_start = r_start;
    assign core_x     = r_core_x;

endmodule
`default_nettype wire

// File: tb/tb_tanh_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tanh_share_arbiter
// Brief    : Self-checking bench for tanh_share_arbiter with a stub tanh core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tanh_share_arbiter;

    localparam int N = 4;
`ifdef TANH_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic          clk;
    logic          rst;
    logic [3:0]    req_valid;
    logic [63:0]   req_x;
    logic [3:0]    req_ack;
    logic [3:0]    rsp_valid;
    logic [15:0]   rsp_y;
    logic          rsp_err;
    logic          busy;
    logic [1:0]    grant_id;
    logic          core_start;
    logic [15:0]   core_x;
    logic          core_ready;
    logic [15:0]   core_y;

    int checks = 0;
    int errors = 0;

    tanh_share_arbiter #(.N_REQ(N), .W(16), .TO_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ack    (req_ack),
        .rsp_valid  (rsp_valid),
        .rsp_y      (rsp_y),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .grant_id   (grant_id),
        .core_start (core_start),
        .core_x     (core_x),
        .core_ready (core_ready),
        .core_y     (core_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub core: ready falls one cycle after start, stays low stub_l cycles, Y = X ^ FFFF.
    int          stub_l;
    bit          stub_hang;
    logic        st_dly;
    logic [15:0] st_x;
    int          st_cnt;

    always @(posedge clk) begin
        if (rst) begin
            st_dly     <= 1'b0;
            st_x       <= '0;
            st_cnt     <= 0;
            core_ready <= 1'b1;
            core_y     <= '0;
        end else begin
            st_dly <= core_start;
            if (core_start) begin
                st_x   <= core_x;
                st_cnt <= stub_l - 1;
            end
            if (st_dly) begin
                core_ready <= 1'b0;
            end else if (!core_ready && !stub_hang) begin
                if (st_cnt == 0) begin
                    core_ready <= 1'b1;
                    core_y     <= st_x ^ 16'hFFFF;
                end else begin
                    st_cnt <= st_cnt - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ack"},      req_ack,    0);
        chk({tag, "_rspv"},     rsp_valid,  0);
        chk({tag, "_rspy"},     rsp_y,      0);
        chk({tag, "_err"},      rsp_err,    0);
        chk({tag, "_busy"},     busy,       0);
        chk({tag, "_grant"},    grant_id,   0);
        chk({tag, "_start"},    core_start, 0);
        chk({tag, "_corex"},    core_x,     0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        stub_hang = 1'b0;
        repeat (3) tick();
        check_quiet("rst");
        rst = 1'b0;
        tick();
    endtask

    // One isolated op from IDLE: ack one cycle after the request, response L+4 after.
    task automatic single_op(input int id, input logic [15:0] x, input int l,
                             input logic [15:0] y, input string nm);
        int early;
        early = 0;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_x[id*16 +: 16] = x;
        stub_l = l;
        tick();
        chk({nm, "_ack"},   req_ack, 32'(4'b0001 << id));
        chk({nm, "_start"}, core_start, 1);
        chk({nm, "_corex"}, core_x, x);
        chk({nm, "_grant"}, grant_id, id);
        chk({nm, "_busy"},  busy, 1);
        req_valid = '0;
        for (int k = 0; k < l + 2; k++) begin
            tick();
            if (rsp_valid != 4'b0 || core_start) early++;
        end
        chk({nm, "_early"}, early, 0);
        tick();
        chk({nm, "_rspv"}, rsp_valid, 32'(4'b0001 << id));
        chk({nm, "_rspy"}, rsp_y, y);
        chk({nm, "_err"},  rsp_err, 0);
        tick();
        chk({nm, "_rspv_end"}, rsp_valid, 0);
        chk({nm, "_idle"},     busy, 0);
        chk({nm, "_hold"},     rsp_y, y);
    endtask

    // Reference model for the randomized phase.
    typedef struct {
        int          id;
        logic [15:0] y;
        int          due;
    } exp_t;

    exp_t q[$];
    int   mptr;

    function automatic int rr_pick(input int p, input logic [3:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic run_random(input int ncyc);
        int   g;
        int   wait_c [4];
        exp_t e;
        mptr = N - 1;
        q.delete();
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        for (int n = 0; n < ncyc; n++) begin
            if (n < ncyc - 60) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b1;
                        req_x[i*16 +: 16] = 16'($urandom);
                    end
                end
            end
            tick();
            if (req_ack != 4'b0) begin
                g = rr_pick(mptr, req_valid);
                chk("rnd_ack", req_ack, (g < 0) ? 32'd0 : 32'(4'b0001 << g));
                chk("rnd_start", core_start, 1);
                if (g >= 0) begin
                    chk("rnd_corex", core_x, req_x[g*16 +: 16]);
                    stub_l = $urandom_range(1, 5);
                    e.id  = g;
                    e.y   = req_x[g*16 +: 16] ^ 16'hFFFF;
                    e.due = n + stub_l + 3;
                    q.push_back(e);
                end
                for (int i = 0; i < N; i++) if (req_ack[i]) wait_c[i] = 0;
                req_valid = req_valid & ~req_ack;
            end else begin
                chk("rnd_nostart", core_start, 0);
            end
            if (rsp_valid != 4'b0) begin
                if (q.size() == 0) begin
                    chk("rnd_rsp_unexp", rsp_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_rsp_id",    rsp_valid, 32'(4'b0001 << e.id));
                    chk("rnd_rsp_y",     rsp_y, e.y);
                    chk("rnd_rsp_err",   rsp_err, 0);
                    chk("rnd_rsp_cycle", n, e.due);
                    mptr = e.id;
                end
            end else if (q.size() > 0 && n > q[0].due) begin
                chk("rnd_rsp_missing", n, q[0].due);
                mptr = q[0].id;
                void'(q.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) wait_c[i]++;
                if (wait_c[i] > 200) begin
                    chk("rnd_starve", wait_c[i], 200);
                    req_valid[i] = 1'b0;
                    wait_c[i] = 0;
                end
            end
        end
        chk("rnd_drain", q.size(), 0);
    endtask

    typedef struct {
        int          id;
        logic [15:0] x;
        int          l;
        logic [15:0] y;
    } vec_t;

    initial begin
        vec_t tv [4];
        int   nack;
        int   nrsp;
        int   bad;
        logic [3:0] rer;
        int   fexp [4];
        logic [15:0] xv;

        tv[0] = '{2, 16'h1234, 6, 16'hEDCB};
        tv[1] = '{0, 16'h0000, 1, 16'hFFFF};
        tv[2] = '{3, 16'hFFFF, 3, 16'h0000};
        tv[3] = '{1, 16'hA5A5, 5, 16'h5A5A};
        fexp  = '{0, 3, 0, 3};

        rst = 1'b1; req_valid = '0; req_x = '0; stub_l = 6; stub_hang = 1'b0;

        do_reset();

        for (int i = 0; i < 4; i++) begin
            single_op(tv[i].id, tv[i].x, tv[i].l, tv[i].y, $sformatf("vec%0d", i));
        end

        // All four at once: after reset the pointer gives order 0,1,2,3.
        do_reset();
        stub_l = 2;
        for (int i = 0; i < N; i++) req_x[i*16 +: 16] = 16'((i + 1) * 16'h1111);
        req_valid = 4'hF;
        nack = 0; nrsp = 0;
        for (int n = 0; n < 120 && nrsp < 4; n++) begin
            tick();
            if (req_ack != 4'b0) begin
                chk($sformatf("all_ack%0d", nack), req_ack, 32'(4'b0001 << nack));
                req_valid = req_valid & ~req_ack;
                nack++;
            end
            if (rsp_valid != 4'b0) begin
                xv = 16'((nrsp + 1) * 16'h1111);
                chk($sformatf("all_rsp%0d", nrsp), rsp_valid, 32'(4'b0001 << nrsp));
                chk($sformatf("all_y%0d", nrsp), rsp_y, xv ^ 16'hFFFF);
                nrsp++;
            end
        end
        chk("all_rsp_count", nrsp, 4);
        chk("all_ack_count", nack, 4);

        // Fairness: 0 and 3 re-request continuously.
        req_valid = 4'b1001;
        rer = '0;
        nack = 0;
        for (int n = 0; n < 120 && nack < 4; n++) begin
            req_valid = req_valid | rer;
            rer = '0;
            tick();
            if (req_ack != 4'b0) begin
                chk($sformatf("fair%0d", nack), req_ack, 32'(4'b0001 << fexp[nack]));
                rer = req_ack;
                req_valid = req_valid & ~req_ack;
                nack++;
            end
        end
        chk("fair_count", nack, 4);
        req_valid = '0;
        repeat (20) tick();

        // Reset while waiting on the core's result.
        stub_l = 6;
        req_valid = 4'b0010;
        req_x[16 +: 16] = 16'h0F0F;
        tick();
        chk("mid_ack", req_ack, 4'b0010);
        req_valid = '0;
        repeat (4) tick();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        check_quiet("mid");
        rst = 1'b0;
        bad = 0;
        repeat (15) begin
            tick();
            if (rsp_valid != 4'b0 || busy) bad++;
        end
        chk("mid_no_rsp", bad, 0);

`ifdef TANH_ARB_TIMEOUT_EN
        stub_hang = 1'b1;
        stub_l = 3;
        req_valid = 4'b0100;
        req_x[32 +: 16] = 16'h5555;
        tick();
        chk("to_ack", req_ack, 4'b0100);
        req_valid = '0;
        bad = 0;
        repeat (8) begin
            tick();
            if (rsp_valid != 4'b0) bad++;
        end
        chk("to_early", bad, 0);
        tick();
        chk("to_rspv", rsp_valid, 4'b0100);
        chk("to_err",  rsp_err, 1);
        chk("to_y",    rsp_y, 0);
        stub_hang = 1'b0;
        repeat (12) tick();
        single_op(2, 16'h1357, 4, 16'hECA8, "to_next");
`endif

        do_reset();
        run_random(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
